// File: rtl/cfu_mac_seq_pkg.sv
// rtl/cfu_mac_seq_pkg.sv - shared opcodes, FSM encoding and lane geometry for cfu_mac_seq
//
// Purpose: constants and types shared by the MAC sequencer and its datapath.
//   OP_*      : funct3 opcodes carried in cmd_payload_function_id[2:0]
//   state_t   : sequencer FSM state encoding
//   LANE_W    : width of one signed operand lane
//   LANES     : number of lanes per 32-bit operand
package cfu_mac_seq_pkg;

  localparam logic [2:0] OP_CLR    = 3'd0;
  localparam logic [2:0] OP_SETOFF = 3'd1;
  localparam logic [2:0] OP_MAC    = 3'd2;
  localparam logic [2:0] OP_RDACC  = 3'd3;
  localparam logic [2:0] OP_MACNR  = 3'd4;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/cfu_mac_pipe.sv
// rtl/cfu_mac_pipe.sv - 2-stage int8 dot-product datapath with 32-bit accumulator
//
// Purpose: pure datapath driven by strobes from the sequencer.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture in_a, in_b, in_off into the operand registers
//   mul_en     : register the four lane products
//   acc_clr    : clear the accumulator
//   acc_we     : write acc_sum into the accumulator
//   in_a/in_b  : four signed LANE_W lanes each, lane0 in the LSBs
//   in_off     : offset added to every sign-extended B lane
//   dot_sum    : sum of the registered lane products
//   acc_sum    : acc + dot_sum (wraps modulo 2^ACC_W)
//   acc        : current accumulator value
module cfu_mac_pipe
  import cfu_mac_seq_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mul_en,
  input  logic             acc_clr,
  input  logic             acc_we,
  input  logic [ACC_W-1:0] in_a,
  input  logic [ACC_W-1:0] in_b,
  input  logic [ACC_W-1:0] in_off,
  output logic [ACC_W-1:0] dot_sum,
  output logic [ACC_W-1:0] acc_sum,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] a_q;
  logic [ACC_W-1:0] b_q;
  logic [ACC_W-1:0] off_q;
  logic [ACC_W-1:0] prod_q [LANES];
  logic [ACC_W-1:0] acc_q;

  // Sign-extended lane slices of the latched operands.
  logic signed [ACC_W-1:0] lane_a [LANES];
  logic signed [ACC_W-1:0] lane_b [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_a[i] = {{(ACC_W-LANE_W){a_q[LANE_W*i+LANE_W-1]}}, a_q[LANE_W*i +: LANE_W]};
      lane_b[i] = {{(ACC_W-LANE_W){b_q[LANE_W*i+LANE_W-1]}}, b_q[LANE_W*i +: LANE_W]};
    end
  end

  // Stage 0: operand capture. The offset is frozen here so the MAC uses the
  // value current at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      off_q <= '0;
    end else if (load) begin
      a_q   <= in_a;
      b_q   <= in_b;
      off_q <= in_off;
    end
  end

  // Stage 1: lane products, truncated to ACC_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (mul_en) begin
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= lane_a[i] * (lane_b[i] + $signed(off_q));
      end
    end
  end

  // Stage 2: adder tree feeding the accumulator.
  always_comb begin
    dot_sum = (prod_q[0] + prod_q[1]) + (prod_q[2] + prod_q[3]);
    acc_sum = acc_q + dot_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (acc_we) begin
      acc_q <= acc_sum;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cfu_mac_seq.sv
// rtl/cfu_mac_seq.sv - CFU command sequencer for the 4-lane int8 dot-product MAC
//
// Purpose: accepts CFU custom-instruction commands, holds the offset register,
// steps the 2-stage MAC datapath and returns results on the rsp handshake.
//   clk, reset               : clock, synchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake (ready only in IDLE)
//   cmd_payload_function_id  : [2:0] funct3 opcode, [9:3] ignored
//   cmd_payload_inputs_0/1   : operands A / B (four signed int8 lanes)
//   rsp_valid / rsp_ready    : response handshake
//   rsp_payload_outputs_0    : response data, held until accepted
module cfu_mac_seq
  import cfu_mac_seq_pkg::*;
#(
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] OFFSET_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_payload_function_id,
  input  logic [ACC_W-1:0] cmd_payload_inputs_0,
  input  logic [ACC_W-1:0] cmd_payload_inputs_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_payload_outputs_0
);

  state_t           state;
  logic [ACC_W-1:0] offset;
  logic             mac_upd;
  logic [2:0]       funct3;
  logic             accept;
  logic             is_mac_op;
  logic             pipe_load;
  logic             mul_en;
  logic             acc_clr;
  logic             acc_we;
  logic [ACC_W-1:0] dot_sum;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc;
  logic             unused_funct7;

  assign funct3        = cmd_payload_function_id[2:0];
  assign unused_funct7 = ^cmd_payload_function_id[9:3];

  // Gated by reset so ready is low for the whole reset window, whatever
  // state the FSM held when reset was raised.
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign is_mac_op = (funct3 == OP_MAC) || (funct3 == OP_MACNR);
  assign pipe_load = accept && is_mac_op;
  assign acc_clr   = accept && (funct3 == OP_CLR);
  assign mul_en    = (state == ST_MUL);
  assign acc_we    = (state == ST_ADD) && mac_upd;

  cfu_mac_pipe #(
    .ACC_W(ACC_W)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .load    (pipe_load),
    .mul_en  (mul_en),
    .acc_clr (acc_clr),
    .acc_we  (acc_we),
    .in_a    (cmd_payload_inputs_0),
    .in_b    (cmd_payload_inputs_1),
    .in_off  (offset),
    .dot_sum (dot_sum),
    .acc_sum (acc_sum),
    .acc     (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_IDLE;
      offset                <= OFFSET_RESET;
      mac_upd               <= 1'b0;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mac_op) begin
              mac_upd <= (funct3 == OP_MAC);
              state   <= ST_MUL;
            end else begin
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
              case (funct3)
                OP_SETOFF: begin
                  offset                <= cmd_payload_inputs_0;
                  rsp_payload_outputs_0 <= offset;
                end
                OP_RDACC: rsp_payload_outputs_0 <= acc;
                default:  rsp_payload_outputs_0 <= '0;
              endcase
            end
          end
        end
        ST_MUL: state <= ST_ADD;
        ST_ADD: begin
          rsp_payload_outputs_0 <= mac_upd ? acc_sum : dot_sum;
          rsp_valid             <= 1'b1;
          state                 <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
